// File: rtl/pool_seq_ctrl_pkg.sv
// Shared feature-path constants, layer-state encodings and the pool read-order decode.
// Pure definitions: no clocked logic and no flow control.
package pool_seq_ctrl_pkg;

   localparam int DATSIZE = 22;
   localparam int PARSIZE = 16;
   localparam int FPSHIFT = 8;

   typedef enum logic [3:0] {
      L_IDLE   = 4'b0000,
      L_READ   = 4'b0001,
      L_CONV1  = 4'b0010,
      L_POOL1  = 4'b0011,
      L_CONV2  = 4'b0100,
      L_POOL2  = 4'b0101,
      L_CONV3  = 4'b0110,
      L_POOL3  = 4'b0111,
      L_DENSE1 = 4'b1000
   } layer_state_t;

   localparam int POOL1_H = 16;
   localparam int POOL1_W = 16;
   localparam int POOL1_C = 16;
   localparam int POOL2_H = 8;
   localparam int POOL2_W = 8;
   localparam int POOL2_C = 32;
   localparam int POOL3_H = 2;
   localparam int POOL3_W = 2;
   localparam int POOL3_C = 64;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FIN
   } seq_state_t;

   typedef enum logic [1:0] {
      M_POOL1,
      M_POOL2,
      M_POOL3
   } pool_mode_t;

   typedef struct packed {
      logic [5:0] ry;
      logic [5:0] rx;
      logic [6:0] rc;
      logic       ud;
      logic       clr;
      logic       last;
      logic [5:0] wy;
      logic [5:0] wx;
      logic [5:0] wc;
   } rd_req_t;

   function automatic logic [13:0] total_reads(input pool_mode_t mode);
      case (mode)
         M_POOL1: total_reads = 14'(2 * POOL1_H * POOL1_W * POOL1_C);
         M_POOL2: total_reads = 14'(2 * POOL2_H * POOL2_W * POOL2_C);
         default: total_reads = 14'(8 * POOL3_H * POOL3_W * POOL3_C);
      endcase
   endfunction

   // Every bound is a power of two, so the nested c/y/x/updown counters are exactly
   // bit fields of one linear read index; a field wrapping is the counter wrapping.
   function automatic rd_req_t decode_idx(input pool_mode_t mode, input logic [13:0] idx);
      rd_req_t r;
      r    = '0;
      r.ud = idx[0];
      case (mode)
         M_POOL1: begin
            r.rx = {2'b0, idx[4:1]};
            r.ry = {2'b0, idx[8:5]};
            r.rc = {3'b0, idx[12:9]};
         end
         M_POOL2: begin
            r.rx = {3'b0, idx[3:1]};
            r.ry = {3'b0, idx[6:4]};
            r.rc = {2'b0, idx[11:7]};
         end
         default: begin
            r.rx = {4'b0, idx[3], idx[1]};
            r.ry = {4'b0, idx[4], idx[2]};
            r.rc = {1'b0, idx[10:5]};
         end
      endcase
      if (mode == M_POOL3) begin
         r.clr  = (idx[2:0] == 3'b000);
         r.last = (idx[2:0] == 3'b111);
         r.wy   = {5'b0, idx[4]};
         r.wx   = {5'b0, idx[3]};
         r.wc   = idx[10:5];
      end else begin
         r.clr  = ~idx[0];
         r.last = idx[0];
         r.wy   = r.ry;
         r.wx   = r.rx;
         r.wc   = r.rc[5:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/pool_seq_ctrl_max2x2.sv
// Signed running max of two lanes per data cycle; i_clr restarts from the current pair.
// Result is registered: o_acc reflects the data one cycle after i_vld. No backpressure.
module pool_max2x2 import pool_seq_ctrl_pkg::*; #(
   parameter int W = DATSIZE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_vld,
   input  logic                i_clr,
   input  logic signed [W-1:0] i_lo,
   input  logic signed [W-1:0] i_hi,
   output logic signed [W-1:0] o_acc
);

   logic signed [W-1:0] r_acc;
   logic signed [W-1:0] w_pair;
   logic signed [W-1:0] w_max;

   always_comb begin
      w_pair = (i_hi > i_lo) ? i_hi : i_lo;
      w_max  = (i_clr || (w_pair > r_acc)) ? w_pair : r_acc;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (i_vld) begin
         r_acc <= w_max;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/pool_seq_ctrl.sv
// Sequences one max-pool layer per start: one double-pixel read per cycle, write 2 cycles after a window's last read.
// No backpressure: the buffers accept a read and a write every cycle; start is ignored while busy.
module pool_seq_ctrl #(
   parameter int DATSIZE = pool_seq_ctrl_pkg::DATSIZE,
   parameter int RD_LAT  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           state,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 pool_read_en,
   output logic [5:0]           pool_read_y,
   output logic [5:0]           pool_read_x,
   output logic [6:0]           pool_read_c,
   output logic                 pool_read_updown,
   input  logic [2*DATSIZE-1:0] pool_read_data,
   output logic                 conv_write_en,
   output logic [5:0]           conv_write_y,
   output logic [5:0]           conv_write_x,
   output logic [5:0]           conv_write_c,
   output logic [DATSIZE-1:0]   conv_write_data
);
   import pool_seq_ctrl_pkg::*;

   // Cycles between the final read and the final write.
   localparam int DRAIN_CYC = RD_LAT + 1;

   seq_state_t   r_st;
   pool_mode_t   r_mode;
   logic [13:0]  r_idx;
   logic [3:0]   r_drn;
   logic         r_busy;
   logic         r_done;
   logic         r_err;

   logic         r_rd_en;
   logic [5:0]   r_rd_y;
   logic [5:0]   r_rd_x;
   logic [6:0]   r_rd_c;
   logic         r_rd_ud;
   logic         r_s0_clr;
   logic         r_s0_last;
   logic [5:0]   r_s0_wy;
   logic [5:0]   r_s0_wx;
   logic [5:0]   r_s0_wc;

   logic         r_s1_vld;
   logic         r_s1_clr;
   logic         r_s1_last;
   logic [5:0]   r_s1_wy;
   logic [5:0]   r_s1_wx;
   logic [5:0]   r_s1_wc;

   logic         r_wr_en;
   logic [5:0]   r_wr_y;
   logic [5:0]   r_wr_x;
   logic [5:0]   r_wr_c;

   logic         w_sup;
   pool_mode_t   w_mode;
   rd_req_t      w_req;
   logic [DATSIZE-1:0] w_acc;

   always_comb begin
      w_sup  = 1'b1;
      w_mode = M_POOL1;
      case (state)
         L_POOL1: w_mode = M_POOL1;
         L_POOL2: w_mode = M_POOL2;
         L_POOL3: w_mode = M_POOL3;
         default: w_sup  = 1'b0;
      endcase
   end

   assign w_req = decode_idx(r_mode, r_idx);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_st      <= S_IDLE;
         r_mode    <= M_POOL1;
         r_idx     <= '0;
         r_drn     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_y    <= '0;
         r_rd_x    <= '0;
         r_rd_c    <= '0;
         r_rd_ud   <= 1'b0;
         r_s0_clr  <= 1'b0;
         r_s0_last <= 1'b0;
         r_s0_wy   <= '0;
         r_s0_wx   <= '0;
         r_s0_wc   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_st)
            S_IDLE: begin
               if (start && w_sup) begin
                  // First read (index 0) goes out directly; the counter continues from 1.
                  r_st      <= S_RUN;
                  r_mode    <= w_mode;
                  r_err     <= 1'b0;
                  r_busy    <= 1'b1;
                  r_idx     <= 14'd1;
                  r_rd_en   <= 1'b1;
                  r_rd_y    <= '0;
                  r_rd_x    <= '0;
                  r_rd_c    <= '0;
                  r_rd_ud   <= 1'b0;
                  r_s0_clr  <= 1'b1;
                  r_s0_last <= 1'b0;
                  r_s0_wy   <= '0;
                  r_s0_wx   <= '0;
                  r_s0_wc   <= '0;
               end else if (start) begin
                  r_st   <= S_FIN;
                  r_err  <= 1'b1;
                  r_done <= 1'b1;
               end
            end
            S_RUN: begin
               if (r_idx == total_reads(r_mode)) begin
                  r_st    <= S_DRAIN;
                  r_rd_en <= 1'b0;
                  r_drn   <= '0;
               end else begin
                  r_rd_en   <= 1'b1;
                  r_rd_y    <= w_req.ry;
                  r_rd_x    <= w_req.rx;
                  r_rd_c    <= w_req.rc;
                  r_rd_ud   <= w_req.ud;
                  r_s0_clr  <= w_req.clr;
                  r_s0_last <= w_req.last;
                  r_s0_wy   <= w_req.wy;
                  r_s0_wx   <= w_req.wx;
                  r_s0_wc   <= w_req.wc;
                  r_idx     <= r_idx + 14'd1;
               end
            end
            S_DRAIN: begin
               if (r_drn == 4'(DRAIN_CYC - 1)) begin
                  r_st   <= S_FIN;
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end else begin
                  r_drn <= r_drn + 4'd1;
               end
            end
            default: r_st <= S_IDLE;
         endcase
      end
   end

   // Read-data stage: control travels one cycle behind the read so it lines up with the data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_clr  <= 1'b0;
         r_s1_last <= 1'b0;
         r_s1_wy   <= '0;
         r_s1_wx   <= '0;
         r_s1_wc   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_y    <= '0;
         r_wr_x    <= '0;
         r_wr_c    <= '0;
      end else begin
         r_s1_vld  <= r_rd_en;
         r_s1_clr  <= r_s0_clr;
         r_s1_last <= r_s0_last;
         r_s1_wy   <= r_s0_wy;
         r_s1_wx   <= r_s0_wx;
         r_s1_wc   <= r_s0_wc;
         r_wr_en   <= r_s1_vld & r_s1_last;
         if (r_s1_vld && r_s1_last) begin
            r_wr_y <= r_s1_wy;
            r_wr_x <= r_s1_wx;
            r_wr_c <= r_s1_wc;
         end
      end
   end

   pool_max2x2 #(.W(DATSIZE)) u_max (
      .clk   (clk),
      .rst_n (rst_n),
      .i_vld (r_s1_vld),
      .i_clr (r_s1_clr),
      .i_lo  (pool_read_data[DATSIZE-1:0]),
      .i_hi  (pool_read_data[2*DATSIZE-1:DATSIZE]),
      .o_acc (w_acc)
   );

   assign busy             = r_busy;
   assign done             = r_done;
   assign err              = r_err;
   assign pool_read_en     = r_rd_en;
   assign pool_read_y      = r_rd_y;
   assign pool_read_x      = r_rd_x;
   assign pool_read_c      = r_rd_c;
   assign pool_read_updown = r_rd_ud;
   assign conv_write_en    = r_wr_en;
   assign conv_write_y     = r_wr_y;
   assign conv_write_x     = r_wr_x;
   assign conv_write_c     = r_wr_c;
   assign conv_write_data  = w_acc;

endmodule
